// File: rtl/jk_excitation_driver.sv
// ---------------------------------------------------------------------------
// jk_excitation_driver
//
// Drives a bank of JK flip-flops to a requested next state. A target vector
// is accepted over a valid/ready handshake. Per-bit J/K values are derived
// from the JK excitation table using the bank's present Q, and are presented
// for exactly one clock. One cycle later the bank's Q is compared against
// the target and the outcome is reported.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   in_valid     target request valid
//   in_ready     block can accept a target (high only in IDLE)
//   target       requested next state of the bank
//   toggle_mode  sampled with target; 1 = use J=K=1 for changing bits
//   q_in         present Q of the driven JK bank
//   j_out        J inputs to the bank (nonzero only in DRIVE)
//   k_out        K inputs to the bank (nonzero only in DRIVE)
//   nchg         number of bits changed by the most recent request
//   done         one-cycle pulse: request completed
//   err          one-cycle pulse with done: bank state != target
//   err_count    saturating count of err pulses
// ---------------------------------------------------------------------------
module jk_excitation_driver #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           target,
  input  logic                       toggle_mode,
  input  logic [WIDTH-1:0]           q_in,
  output logic [WIDTH-1:0]           j_out,
  output logic [WIDTH-1:0]           k_out,
  output logic [$clog2(WIDTH+1)-1:0] nchg,
  output logic                       done,
  output logic                       err,
  output logic [ERRW-1:0]            err_count
);

  localparam int NW = $clog2(WIDTH+1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] j_next;
  logic [WIDTH-1:0] k_next;
  logic [NW-1:0]    pop;
  logic             mismatch;

  assign in_ready = (state == IDLE);
  assign mismatch = (q_in != target_q);

  // Excitation table folded into masks: only changing bits get J or K.
  // A 0->1 bit needs J, a 1->0 bit needs K; toggle mode asserts both on
  // every changing bit. toggle_mode is consumed here at the accept edge, so
  // it never needs to be stored.
  always_comb begin
    diff   = q_in ^ target;
    j_next = diff & (~q_in | {WIDTH{toggle_mode}});
    k_next = diff & ( q_in | {WIDTH{toggle_mode}});
    pop    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + NW'(diff[i]);
    end
  end

  // Three-phase sequencer: accept in IDLE, present J/K for one cycle in
  // DRIVE, then compare the bank against the latched target on the CHECK
  // exit edge. done/err default low so they pulse for a single cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      target_q  <= '0;
      j_out     <= '0;
      k_out     <= '0;
      nchg      <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= DRIVE;
            target_q <= target;
            j_out    <= j_next;
            k_out    <= k_next;
            nchg     <= pop;
          end
        end
        DRIVE: begin
          j_out <= '0;
          k_out <= '0;
          state <= CHECK;
        end
        CHECK: begin
          done  <= 1'b1;
          err   <= mismatch;
          if (mismatch && (err_count != '1)) begin
            err_count <= err_count + ERRW'(1);
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// ---------------------------------------------------------------------------
// tb_jk_excitation_driver
//
// Drives jk_excitation_driver against a behavioural JK register bank (with an
// optional stuck-at-0 mask) and compares every observable output with values
// computed from the excitation table, the transaction timing and a
// saturating error counter model.
// ---------------------------------------------------------------------------
module tb_jk_excitation_driver;

  localparam int W = 4;
  localparam int E = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] target = '0;
  logic         toggle_mode = 1'b0;
  logic [W-1:0] q_in;
  logic [W-1:0] j_out;
  logic [W-1:0] k_out;
  logic [2:0]   nchg;
  logic         done;
  logic         err;
  logic [E-1:0] err_count;

  logic [W-1:0] bank_q;
  logic [W-1:0] load_val = '0;
  logic         load_en = 1'b0;
  logic [W-1:0] stuck0 = '0;

  int checks = 0;
  int errors = 0;
  int exp_errcnt = 0;

  always #5 clk = ~clk;

  // The JK register bank being driven: textbook JK behaviour per bit, with
  // a preload port and bits in stuck0 forced to 0.
  always @(posedge clk) begin
    if (load_en) bank_q <= load_val & ~stuck0;
    else         bank_q <= ((j_out & ~bank_q) | (~k_out & bank_q)) & ~stuck0;
  end

  assign q_in = bank_q;

  jk_excitation_driver #(.WIDTH(W), .ERRW(E)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .target(target), .toggle_mode(toggle_mode), .q_in(q_in),
    .j_out(j_out), .k_out(k_out), .nchg(nchg), .done(done), .err(err),
    .err_count(err_count)
  );

  // Excitation table, one bit at a time.
  function automatic logic [W-1:0] model_j(input logic [W-1:0] q, t, input logic tm);
    logic [W-1:0] r = '0;
    for (int i = 0; i < W; i++) begin
      case ({q[i], t[i]})
        2'b01:   r[i] = 1'b1;
        2'b10:   r[i] = tm;
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [W-1:0] model_k(input logic [W-1:0] q, t, input logic tm);
    logic [W-1:0] r = '0;
    for (int i = 0; i < W; i++) begin
      case ({q[i], t[i]})
        2'b10:   r[i] = 1'b1;
        2'b01:   r[i] = tm;
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic int model_n(input logic [W-1:0] q, t);
    int n = 0;
    for (int i = 0; i < W; i++) if (q[i] != t[i]) n++;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge, returns at the next negedge.
  task automatic loadBank(input logic [W-1:0] v);
    load_en  = 1'b1;
    load_val = v;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  // One full transaction. Called at a negedge with the DUT idle; returns at
  // the negedge where done is visible (DUT idle again).
  task automatic applyStimulus(input logic [W-1:0] t, input logic tm);
    logic [W-1:0] q0;
    logic [W-1:0] final_q;
    logic         exp_err;
    q0 = bank_q;
    checkOutput("ready_idle", in_ready, 1);
    in_valid    = 1'b1;
    target      = t;
    toggle_mode = tm;
    @(negedge clk);
    in_valid    = 1'b0;
    target      = W'($urandom);
    toggle_mode = 1'($urandom);
    checkOutput("j_drive", j_out, model_j(q0, t, tm));
    checkOutput("k_drive", k_out, model_k(q0, t, tm));
    checkOutput("nchg", nchg, model_n(q0, t));
    checkOutput("ready_drive", in_ready, 0);
    checkOutput("done_drive", done, 0);
    @(negedge clk);
    final_q = t & ~stuck0;
    checkOutput("j_check", j_out, 0);
    checkOutput("k_check", k_out, 0);
    checkOutput("ready_check", in_ready, 0);
    checkOutput("done_check", done, 0);
    checkOutput("bank", bank_q, final_q);
    @(negedge clk);
    exp_err = (final_q != t);
    if (exp_err && exp_errcnt < 255) exp_errcnt++;
    checkOutput("done", done, 1);
    checkOutput("err", err, exp_err);
    checkOutput("err_count", err_count, exp_errcnt);
    checkOutput("ready_after", in_ready, 1);
    checkOutput("nchg_hold", nchg, model_n(q0, t));
  endtask

  initial begin
    logic [W-1:0] acc_t;
    logic [W-1:0] acc_q;

    // Reset held with random inputs.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid    = 1'($urandom);
      target      = W'($urandom);
      toggle_mode = 1'($urandom);
      load_en     = 1'b1;
      load_val    = W'($urandom);
      if (c > 0) begin
        checkOutput("rst_j", j_out, 0);
        checkOutput("rst_k", k_out, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_errcnt", err_count, 0);
        checkOutput("rst_ready", in_ready, 1);
        checkOutput("rst_nchg", nchg, 0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    load_en  = 1'b0;
    rst      = 1'b1;
    $display("[TB] reset released");

    // Basic set/reset.
    loadBank(4'b0000);
    applyStimulus(4'b1010, 1'b0);
    applyStimulus(4'b0011, 1'b0);

    // Toggle mode.
    loadBank(4'b0110);
    applyStimulus(4'b1001, 1'b1);

    // Hold: no bits change, still a full transaction.
    loadBank(4'b0101);
    applyStimulus(4'b0101, 1'b0);

    // Random requests chained back to back.
    for (int n = 0; n < 20; n++) begin
      applyStimulus(W'($urandom), 1'($urandom));
    end

    // Handshake: in_valid held high with a new target every cycle.
    toggle_mode = 1'b0;
    acc_t = '0;
    acc_q = '0;
    for (int c = 0; c <= 12; c++) begin
      if (c % 3 == 1) begin
        checkOutput("hs_j", j_out, model_j(acc_q, acc_t, 1'b0));
        checkOutput("hs_k", k_out, model_k(acc_q, acc_t, 1'b0));
        checkOutput("hs_nchg", nchg, model_n(acc_q, acc_t));
      end
      if (c % 3 == 2) checkOutput("hs_bank", bank_q, acc_t);
      if (c % 3 == 0 && c > 0) begin
        checkOutput("hs_done", done, 1);
        checkOutput("hs_err", err, 0);
      end
      if (c % 3 != 0) checkOutput("hs_done_low", done, 0);
      checkOutput("hs_ready", in_ready, (c % 3 == 0));
      if (c < 12) begin
        in_valid = 1'b1;
        target   = W'($urandom);
        if (c % 3 == 0) begin
          acc_t = target;
          acc_q = bank_q;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Fault injection: bit 0 stuck at 0, then saturate the counter.
    stuck0 = 4'b0001;
    loadBank(4'b0000);
    applyStimulus(4'b0001, 1'b0);
    for (int n = 0; n < 300; n++) begin
      applyStimulus(4'b0001, 1'b0);
    end
    checkOutput("errcnt_sat", err_count, 255);
    stuck0 = '0;

    // Reset pulse mid-DRIVE: outputs clear at once and the request is dropped.
    loadBank(4'b0000);
    in_valid = 1'b1;
    target   = 4'b1111;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("mid_j_before", j_out, 4'b1111);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_j_clear", j_out, 0);
    checkOutput("mid_k_clear", k_out, 0);
    checkOutput("mid_errcnt", err_count, 0);
    checkOutput("mid_ready", in_ready, 1);
    exp_errcnt = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("mid_no_done", done, 0);
    end
    applyStimulus(4'b1010, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Drives a bank of JK flip-flops to a requested next state. A target vector is accepted over a valid/ready handshake. The block derives per-bit J/K inputs from the JK excitation table, using the bank's present Q, and presents them for exactly one clock. It then checks that the bank actually reached the target and reports the result. It sits upstream of any JK register bank in the design and is the write-side counterpart to the flip-flop's J/K-to-Q behaviour.

## Interface
- WIDTH, 4, number of JK flip-flops driven (1..32)
- ERRW, 8, width of saturating mismatch counter

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  target request valid
- in_ready  out  1  block can accept a target
- target  in  WIDTH  requested next state of the bank
- toggle_mode  in  1  sampled with target; 1 = use J=K=1 for changing bits
- q_in  in  WIDTH  present Q of the driven JK bank
- j_out  out  WIDTH  J inputs to the bank
- k_out  out  WIDTH  K inputs to the bank
- nchg  out  $clog2(WIDTH+1)  number of bits changed by the current request
- done  out  1  one-cycle pulse: request completed
- err  out  1  one-cycle pulse with done: bank state != target
- err_count  out  ERRW  saturating count of err pulses

## Operation
- Single clock; reset is asynchronous, active-low.
- While rst=0, all registers clear immediately: state=IDLE, j_out=0, k_out=0, nchg=0, done=0, err=0, err_count=0. in_ready=1 because it is decoded from IDLE.
- States:
  - IDLE: in_ready=1. When in_valid=1, go to DRIVE and latch target and toggle_mode.
  - DRIVE: always lasts one cycle, then go to CHECK.
  - CHECK: always lasts one cycle, then go to IDLE.
- On the accept edge, using q_in sampled at that edge, register per bit i:
  - q=0, t=0: J=0, K=0
  - q=0, t=1: J=1, K=0 (toggle_mode=1: J=1, K=1)
  - q=1, t=0: J=0, K=1 (toggle_mode=1: J=1, K=1)
  - q=1, t=1: J=0, K=0
- Also on the accept edge, register nchg = popcount(q_in ^ target). nchg holds until the next accept.
- j_out/k_out are nonzero only during DRIVE. They are cleared on the DRIVE->CHECK edge.
- On the CHECK->IDLE edge, compare q_in against the latched target:
  - done <= 1.
  - err <= (q_in != target_latched).
  - If err: err_count increments, saturating at 2^ERRW-1.
- in_valid outside IDLE is ignored: not queued, no effect.
- target and toggle_mode changes after acceptance are ignored.
- q_in is sampled only on the accept edge and the CHECK exit edge. Glitches at other times are ignored.

## Timing
- Edge E0: request accepted (in_valid & in_ready).
- Cycle after E0: state DRIVE, j_out/k_out valid, in_ready=0.
- Edge E1: the JK bank samples J/K; the block moves to CHECK and clears j_out/k_out.
- Edge E2: compare; done/err registered; state IDLE.
- Cycle after E2: done (and err if mismatched) high, in_ready=1. A new request may be accepted on E3.
- Throughput: one request per 3 cycles. Latency E0 to done visible: 3 edges (done high in the cycle after E2).
- A request with target == q_in still runs the full sequence: J=K=0, nchg=0, done=1, err=0.
- Reset mid-operation (DRIVE or CHECK):
  - Outputs clear asynchronously.
  - done is not issued and the request is dropped.
  - err_count resets to 0.
- Simultaneous done pulse and new in_valid: acceptance happens on the following edge (E3). done does not block it.

## Test plan
- Reset: hold rst=0 with random inputs, then release. j_out=0, k_out=0, done=0, err=0, err_count=0, in_ready=1. Pulse rst low mid-DRIVE: j_out clears immediately and no done follows.
- Basic set/reset (WIDTH=4, bench JK model on j_out/k_out):
  - q=0000, target=1010, toggle_mode=0: DRIVE shows j=1010, k=0000; nchg=2; q becomes 1010; done=1, err=0.
  - Then target=0011: j=0001, k=1000, nchg=2.
- Toggle mode: q=0110, target=1001, toggle_mode=1 -> j=1111, k=1111, nchg=4, q=1001, err=0.
- Hold: q=0101, target=0101 -> j=k=0000, nchg=0, done=1, err=0, and the transaction takes the full 3 cycles.
- Fault injection:
  - Bench forces bit 0 of the bank stuck at 0. Target 0001 -> err=1 with done, err_count=1.
  - Repeat 300 times with ERRW=8: err_count saturates at 255.
- Handshake: keep in_valid high continuously with changing targets.
  - Accepts occur exactly every 3 cycles.
  - Targets presented during DRIVE/CHECK are ignored.
  - in_ready is high only in IDLE cycles.
